// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and default constants for the countdown timer.
//  Revision    : 1.0  - initial release
// ============================================================================
package timer_pkg;

    // Controller states. The width is explicit so the encoding never depends
    // on the tool.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // 1 Hz decrement on the 50 MHz board clock.
    localparam int DEFAULT_TICK_DIV = 50_000_000;

    // Matches the 4-bit display/LED path.
    localparam int DEFAULT_WIDTH    = 4;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Control and status bundle of the countdown timer. The
//                master side (button logic) drives the preset and strobes;
//                the slave side (the timer) returns count and status.
//  Revision    : 1.0  - initial release
// ============================================================================
interface countdown_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] init;
    logic             load;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             expired;

    modport master (
        output init,
        output load,
        output start,
        output pause,
        input  count,
        input  running,
        input  done,
        input  expired
    );

    modport slave (
        input  init,
        input  load,
        input  start,
        input  pause,
        output count,
        output running,
        output done,
        output expired
    );

endinterface : countdown_timer_if
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler for the countdown timer. Counts down while enabled
//                and flags a one-cycle tick when it sits at zero, reloading
//                to TICK_DIV-1 on that same edge. Holds its phase while
//                disabled so a pause/resume keeps the partial period.
//  Revision    : 1.0  - initial release
// ============================================================================
module tick_gen
    import timer_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
)(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);

    localparam int                PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]     c_reload = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;

    // Tick is asserted during the cycle in which the prescaler reads zero
    // while enabled, so the consuming register updates on the same edge
    // that reloads the prescaler.
    assign tick = en && (r_presc == '0);

    // Prescaler: reload on reset/clear, count only while enabled.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_presc <= c_reload;
        end else if (en) begin
            if (r_presc == '0) begin
                r_presc <= c_reload;
            end else begin
                r_presc <= r_presc - 1'b1;
            end
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter. Decrements once per prescaled tick
//                from a preset value to zero, then pulses done for one cycle
//                and holds expired until reloaded. All outputs registered.
//  Revision    : 1.0  - initial release
// ============================================================================
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
)(
    input  wire logic          clk,
    input  wire logic          reset,
    countdown_timer_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_running;
    logic             r_done;
    logic             r_expired;

    logic             w_tick;
    logic             w_presc_en;
    logic             w_presc_clr;

    // The prescaler runs only in RUN; a load or a fresh start from IDLE
    // restarts its phase, while resuming from PAUSE keeps it.
    assign w_presc_en  = (r_state == RUN);
    assign w_presc_clr = bus.load || ((r_state == IDLE) && bus.start);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (w_presc_en),
        .clr   (w_presc_clr),
        .tick  (w_tick)
    );

    // Controller: state, count and registered status outputs.
    // Input priority is reset > load > start > pause.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.load) begin
                r_state   <= IDLE;
                r_count   <= bus.init;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            if (r_count != '0) begin
                                r_state   <= RUN;
                                r_running <= 1'b1;
                            end else begin
                                // Nothing to count: finish immediately.
                                r_state   <= DONE;
                                r_done    <= 1'b1;
                                r_expired <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (w_tick && (r_count != '0)) begin
                            r_count <= r_count - c_one;
                            if (r_count == c_one) begin
                                // Reaching zero beats a coincident pause.
                                r_state   <= DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                                r_expired <= 1'b1;
                            end else if (bus.pause) begin
                                r_state   <= PAUSE;
                                r_running <= 1'b0;
                            end
                        end else if (bus.pause) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (bus.start) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    DONE: begin
                        // Only load or reset leave DONE; count stays at zero.
                        r_count <= '0;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.running = r_running;
    assign bus.done    = r_done;
    assign bus.expired = r_expired;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer (WIDTH=4,
//                TICK_DIV=4). A cycle table covers reset, a basic countdown
//                and the zero-start case; short sequences cover pause/resume,
//                reload mid-run, reset mid-run and the tick/pause collision.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_countdown_timer;

    logic clk;
    logic reset;

    countdown_timer_if #(.WIDTH(4)) bus();

    countdown_timer #(
        .WIDTH    (4),
        .TICK_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] ini;
        logic       st;
        logic       ps;
        logic [3:0] e_count;
        logic       e_run;
        logic       e_done;
        logic       e_exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Drive one cycle of inputs on the falling edge, then let the rising
    // edge sample them and settle just after it.
    task automatic cyc(input logic r, input logic l, input logic [3:0] i,
                       input logic s, input logic p);
        @(negedge clk);
        reset     = r;
        bus.load  = l;
        bus.init  = i;
        bus.start = s;
        bus.pause = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [3:0] c, input logic r,
                       input logic d, input logic e);
        n_checks++;
        if (bus.count === c && bus.running === r && bus.done === d && bus.expired === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got count=%0d running=%b done=%b expired=%b, expected count=%0d running=%b done=%b expired=%b",
                     name, bus.count, bus.running, bus.done, bus.expired, c, r, d, e);
        end
    endtask

    vec_t tbl[25];

    initial begin
        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.init  = 4'd0;
        bus.start = 1'b0;
        bus.pause = 1'b0;

        //          rst  ld  ini   st  ps   count run done exp
        tbl[0]  = '{1'b1,1'b1,4'd7,1'b1,1'b0, 4'd0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,4'd7,1'b1,1'b0, 4'd0,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,4'd3,1'b0,1'b0, 4'd3,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,4'd0,1'b1,1'b0, 4'd3,1'b1,1'b0,1'b0}; // S
        tbl[4]  = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd3,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,4'd0,1'b1,1'b0, 4'd3,1'b1,1'b0,1'b0}; // start ignored in RUN
        tbl[6]  = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd3,1'b1,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd2,1'b1,1'b0,1'b0}; // S+4
        tbl[8]  = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd2,1'b1,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd2,1'b1,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd2,1'b1,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd1,1'b1,1'b0,1'b0}; // S+8
        tbl[12] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd1,1'b1,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd1,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd1,1'b1,1'b0,1'b0};
        tbl[15] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0,1'b0,1'b1,1'b1}; // S+12
        tbl[16] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b1};
        tbl[17] = '{1'b0,1'b0,4'd0,1'b1,1'b0, 4'd0,1'b0,1'b0,1'b1}; // start ignored in DONE
        tbl[18] = '{1'b0,1'b0,4'd0,1'b0,1'b1, 4'd0,1'b0,1'b0,1'b1};
        tbl[19] = '{1'b0,1'b1,4'd0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0}; // load 0
        tbl[20] = '{1'b0,1'b0,4'd0,1'b1,1'b0, 4'd0,1'b0,1'b1,1'b1}; // zero start
        tbl[21] = '{1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b1};
        tbl[22] = '{1'b0,1'b0,4'd0,1'b1,1'b0, 4'd0,1'b0,1'b0,1'b1};
        tbl[23] = '{1'b0,1'b1,4'd2,1'b0,1'b0, 4'd2,1'b0,1'b0,1'b0};
        tbl[24] = '{1'b0,1'b0,4'd0,1'b0,1'b1, 4'd2,1'b0,1'b0,1'b0}; // pause ignored in IDLE

        for (int v = 0; v < 25; v++) begin
            cyc(tbl[v].rst, tbl[v].ld, tbl[v].ini, tbl[v].st, tbl[v].ps);
            chk($sformatf("table[%0d]", v), tbl[v].e_count, tbl[v].e_run,
                tbl[v].e_done, tbl[v].e_exp);
        end

        // Pause/resume: init=5, start at S, pause at S+6, resume at S+16.
        cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);               // S
        idle(4);                                         // S+4
        chk("pause_first_dec", 4'd4, 1'b1, 1'b0, 1'b0);
        idle(1);                                         // S+5
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);               // S+6
        chk("pause_enter", 4'd4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin                // S+7..S+15
            cyc(1'b0, 1'b0, 4'd0, 1'b0, (k == 3));       // repeat pause ignored
        end
        chk("pause_hold", 4'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);               // S+16
        chk("pause_resume", 4'd4, 1'b1, 1'b0, 1'b0);
        idle(1);                                         // S+17
        chk("pause_phase_kept", 4'd4, 1'b1, 1'b0, 1'b0);
        idle(1);                                         // S+18
        chk("pause_dec_3", 4'd3, 1'b1, 1'b0, 1'b0);
        idle(3);                                         // S+21
        chk("pause_before_2", 4'd3, 1'b1, 1'b0, 1'b0);
        idle(1);                                         // S+22
        chk("pause_dec_2", 4'd2, 1'b1, 1'b0, 1'b0);

        // Reload mid-run: init=3, count reaches 2 at S+4, load 9 at S+6.
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(5);
        chk("reload_pre", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        chk("reload_load", 4'd9, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("reload_idle_hold", 4'd9, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);               // S'
        idle(3);                                         // S'+3
        chk("reload_before_dec", 4'd9, 1'b1, 1'b0, 1'b0);
        idle(1);                                         // S'+4
        chk("reload_first_dec", 4'd8, 1'b1, 1'b0, 1'b0);

        // Reset mid-run overrides load and start on the same edge.
        cyc(1'b1, 1'b1, 4'd6, 1'b1, 1'b1);
        chk("reset_mid_run", 4'd0, 1'b0, 1'b0, 1'b0);

        // Tick/pause collision at count=1: DONE wins over PAUSE.
        cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);               // S
        idle(3);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);               // S+4 with pause
        chk("collide_done", 4'd0, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("collide_pulse_end", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);               // would resume if PAUSE
        idle(1);
        chk("collide_not_pause", 4'd0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_countdown_timer
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that decrements once per prescaled tick (1 Hz on the 50 MHz board clock) from a preset value to zero. It raises a one-cycle `done` pulse and a sticky `expired` flag when it reaches zero. It is the count-down counterpart of the team's free-running up-counter and drives the same 4-bit display/LED path. Start and pause are single-cycle strobes from debounced buttons.

## Interface
- `WIDTH`, default 4: count width in bits.
- `TICK_DIV`, default 50_000_000: clk cycles per decrement; must be ≥ 2. Benches use 4.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `init`  in  WIDTH  preset value, sampled when `load` = 1.
- `load`  in  1  load `init` into count; return to IDLE.
- `start`  in  1  start or resume counting.
- `pause`  in  1  freeze counting; prescaler phase is retained.
- `count`  out  WIDTH  current remaining count.
- `running`  out  1  high in RUN state.
- `done`  out  1  one-cycle pulse on reaching zero.
- `expired`  out  1  high in DONE state.

## Operation
- Input priority, sampled each rising edge: `reset` > `load` > `start` > `pause`.
- Reset:
  - State goes to IDLE.
  - `count` = 0, `running` = 0, `done` = 0, `expired` = 0.
  - Prescaler = TICK_DIV-1.
- Prescaler:
  - Counts down only in RUN.
  - At 0 it produces an internal `tick` for one cycle and reloads to TICK_DIV-1.
  - It reloads to TICK_DIV-1 on reset, on `load`, and on IDLE→RUN.
  - It holds its value in PAUSE, IDLE and DONE.
- `load`, in any state: `count` ← `init`, state → IDLE, `expired` ← 0, prescaler reloaded.
- IDLE state:
  - `start` with `count` ≠ 0 → RUN.
  - `start` with `count` = 0 → DONE, with `done` pulsed.
  - `pause` is ignored.
- RUN state:
  - On `tick`, `count` ← `count` - 1.
  - If that tick takes `count` from 1 to 0 → DONE, with `done` = 1 for that cycle.
  - `pause` → PAUSE.
  - `start` is ignored.
- PAUSE state: `start` → RUN with no prescaler reload, so the remaining phase continues. `pause` is ignored.
- DONE state:
  - `count` holds 0 and `expired` = 1.
  - `start` and `pause` are ignored. Only `load` or `reset` leaves DONE.
- Simultaneous `tick` and `pause` in RUN:
  - The decrement is applied and the next state is PAUSE.
  - If the decrement reaches 0, DONE wins and `done` pulses.
- Arithmetic: `count` never decrements below 0. The prescaler is $clog2(TICK_DIV) bits wide.

## Timing
- All outputs are registered. There is no combinational input→output path.
- `running` rises on the edge that samples `start` (edge S).
- The first decrement is at edge S+TICK_DIV. Decrement k is at edge S+k·TICK_DIV.
- Start to `done` takes exactly `init`·TICK_DIV cycles when there are no pauses.
- `done` is high for exactly one cycle, coincident with `count` becoming 0 and `expired` rising.
- Pausing for P cycles delays all later decrements by exactly P cycles.
- `load` takes effect on the sampling edge. `count` shows `init` in the following cycle.
- `reset` asserted mid-operation clears everything on that edge, regardless of other inputs.

## Structure
- Package `timer_pkg`:
  - enum `timer_state_t` {IDLE, RUN, PAUSE, DONE}.
  - constants `DEFAULT_TICK_DIV` = 50_000_000 and `DEFAULT_WIDTH` = 4.
- Sub-module `tick_gen` (params: TICK_DIV):
  - inputs `clk`, `reset`, `en`, `clr`.
  - output `tick`.
  - The top module drives `en` = (state == RUN) and `clr` = load | (IDLE & start).
- Top module `countdown_timer`: holds the FSM and the count register.

## Test plan
All scenarios use WIDTH=4 and TICK_DIV=4.
- **Reset:** hold `reset` 2 cycles with `load` and `start` also high → `count` = 0, `running` = 0, `done` = 0, `expired` = 0.
- **Basic countdown:** `load` `init`=3, then `start` at edge S → `count` = 2, 1, 0 at S+4, S+8, S+12; `done` high only in the cycle after S+12; `expired` = 1; `running` = 0.
- **Pause:** `init`=5, `start` at S, `pause` at S+6 (`count` = 4), hold 10 cycles, `start` at S+16 → `count` still 4 during PAUSE; `count` = 3 at S+18; `count` = 2 at S+22.
- **Zero start:** `load` `init`=0, then `start` → next cycle `done` = 1 for one cycle and `expired` = 1; a later `start` changes nothing.
- **Reload mid-run:** `load` `init`=9 during RUN with `count` = 2 → `count` = 9, `running` = 0, no `done`; `start` again → first decrement 4 cycles later.
- **Tick/pause collision:** `pause` on the tick edge with `count` = 1 → `count` = 0, `done` pulses, state DONE, not PAUSE.
